// File: rtl/clk_div_scheduler.sv
// clk_div_scheduler: run-time controller for the board clock divider.
// Produces a programmable 50% duty square wave (clk_out) plus a one-cycle
// tick on each rising edge. The half-period is changed through a req/ack
// handshake and only takes effect at a full-period boundary (falling edge),
// so clk_out never shows a runt pulse.
//
// Handshake: a request is div_req=1 with div_val. It is sampled only while
// busy=0 and while no div_ack/div_err pulse is being presented; a requester
// that holds div_req until it sees div_ack or div_err is therefore never
// accepted twice. Each accepted request is answered by exactly one div_ack
// (value now in cur_div) or one div_err (div_val==0, nothing changed).
// A request latched while running raises busy until the period boundary.
module clk_div_scheduler #(
   parameter int          W            = 25,
   parameter int unsigned DEFAULT_HALF = 5_000_000
) (
   input  logic         CLK100MHZ,
   input  logic         CPU_RESETN,
   input  logic         enable,
   input  logic         div_req,
   input  logic [W-1:0] div_val,
   output logic         div_ack,
   output logic         div_err,
   output logic         busy,
   output logic [W-1:0] cur_div,
   output logic         clk_out,
   output logic         tick
);

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_e;

   localparam logic [W-1:0] RESET_HALF = W'(DEFAULT_HALF);

   state_e       state_q;
   logic [W-1:0] ctr_q;
   logic [W-1:0] cur_div_q;
   logic [W-1:0] pend_q;
   logic         clk_out_q;
   logic         tick_q;
   logic         busy_q;
   logic         ack_q;
   logic         err_q;

   logic         req_ok;
   logic         val_zero;
   logic         at_wrap;
   logic [W-1:0] ctr_d;

   // Request qualification and half-period wrap detection.
   always_comb begin
      req_ok   = div_req && !busy_q && !ack_q && !err_q;
      val_zero = (div_val == '0);
      // cur_div_q is never zero, so cur_div_q-1 cannot wrap.
      at_wrap  = (ctr_q == (cur_div_q - W'(1)));
      ctr_d    = at_wrap ? '0 : (ctr_q + W'(1));
   end

   // Divider FSM: STOP parks the output, RUN counts, PEND counts while a new
   // half-period waits for the falling edge that ends the current period.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q   <= ST_STOP;
         ctr_q     <= '0;
         cur_div_q <= RESET_HALF;
         pend_q    <= '0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_STOP: begin
               ctr_q     <= '0;
               clk_out_q <= 1'b0;
               // While stopped there is no period to protect: apply at once.
               if (req_ok) begin
                  if (val_zero) begin
                     err_q <= 1'b1;
                  end else begin
                     cur_div_q <= div_val;
                     ack_q     <= 1'b1;
                  end
               end
               if (enable) state_q <= ST_RUN;
            end

            ST_RUN, ST_PEND: begin
               if (!enable) begin
                  // Stop wins over any boundary in the same cycle.
                  state_q   <= ST_STOP;
                  ctr_q     <= '0;
                  clk_out_q <= 1'b0;
                  busy_q    <= 1'b0;
                  if (state_q == ST_PEND) begin
                     cur_div_q <= pend_q;
                     ack_q     <= 1'b1;
                  end else if (req_ok) begin
                     if (val_zero) begin
                        err_q <= 1'b1;
                     end else begin
                        cur_div_q <= div_val;
                        ack_q     <= 1'b1;
                     end
                  end
               end else begin
                  ctr_q <= ctr_d;
                  if (at_wrap) begin
                     clk_out_q <= ~clk_out_q;
                     tick_q    <= ~clk_out_q;
                  end
                  if (state_q == ST_PEND) begin
                     // Falling edge closes the full period: swap in the new value.
                     if (at_wrap && clk_out_q) begin
                        cur_div_q <= pend_q;
                        ack_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_RUN;
                     end
                  end else if (req_ok) begin
                     if (val_zero) begin
                        err_q <= 1'b1;
                     end else begin
                        pend_q  <= div_val;
                        busy_q  <= 1'b1;
                        state_q <= ST_PEND;
                     end
                  end
               end
            end

            default: begin
               state_q   <= ST_STOP;
               ctr_q     <= '0;
               clk_out_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign div_ack = ack_q;
   assign div_err = err_q;
   assign busy    = busy_q;
   assign cur_div = cur_div_q;
   assign clk_out = clk_out_q;
   assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_scheduler.sv
// Bench for clk_div_scheduler with W=8, DEFAULT_HALF=4.
module tb_clk_div_scheduler;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         enable;
   logic         div_req;
   logic [W-1:0] div_val;
   logic         div_ack;
   logic         div_err;
   logic         busy;
   logic [W-1:0] cur_div;
   logic         clk_out;
   logic         tick;

   clk_div_scheduler #(.W(W), .DEFAULT_HALF(4)) dut (
      .CLK100MHZ (clk),
      .CPU_RESETN(rst_n),
      .enable    (enable),
      .div_req   (div_req),
      .div_val   (div_val),
      .div_ack   (div_ack),
      .div_err   (div_err),
      .busy      (busy),
      .cur_div   (cur_div),
      .clk_out   (clk_out),
      .tick      (tick)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_pass   = 0;

   // Scoreboard: expected cur_div on each ack / each err.
   logic [W-1:0] exp_ack_q[$];
   logic [W-1:0] exp_err_q[$];

   logic prev_clk  = 1'b0;
   logic prev_tick = 1'b0;
   logic prev_ack  = 1'b0;
   logic prev_err  = 1'b0;
   logic last_rose = 1'b0;

   typedef struct {
      logic [W-1:0] val;
      int           exp_first;
      int           exp_period;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // One clock: sample #1 after the edge, run per-cycle scoreboard checks.
   task automatic cyc();
      logic rose;
      @(posedge clk);
      #1;
      rose = clk_out && !prev_clk;
      if (tick || rose) chk("tick_on_rise", tick, rose);
      if (prev_tick) chk("tick_single", tick, 0);
      if (prev_ack)  chk("ack_single", div_ack, 0);
      if (prev_err)  chk("err_single", div_err, 0);
      if (div_ack) begin
         if (exp_ack_q.size() == 0) chk("stray_ack", div_ack, 0);
         else chk("ack_cur_div", cur_div, exp_ack_q.pop_front());
      end
      if (div_err) begin
         if (exp_err_q.size() == 0) chk("stray_err", div_err, 0);
         else chk("err_cur_div", cur_div, exp_err_q.pop_front());
      end
      last_rose = rose;
      prev_clk  = clk_out;
      prev_tick = tick;
      prev_ack  = div_ack;
      prev_err  = div_err;
   endtask

   task automatic wait_rise(input int budget, output int n);
      n = 0;
      for (int i = 0; i < budget; i++) begin
         cyc();
         n++;
         if (last_rose) break;
      end
      chk("rise_seen", last_rose, 1);
   endtask

   task automatic wait_ack(input int budget, output int n);
      n = 0;
      for (int i = 0; i < budget; i++) begin
         cyc();
         n++;
         if (div_ack) break;
      end
      chk("ack_seen", div_ack, 1);
   endtask

   task automatic count_ticks(input int cycles, output int nt);
      nt = 0;
      for (int i = 0; i < cycles; i++) begin
         cyc();
         if (tick) nt++;
      end
   endtask

   initial begin
      vec_t vecs[6];
      int   n;
      int   nt;

      vecs[0] = '{val: 8'd6,   exp_first: 7,   exp_period: 12};
      vecs[1] = '{val: 8'd255, exp_first: 256, exp_period: 510};
      vecs[2] = '{val: 8'd1,   exp_first: 2,   exp_period: 2};
      vecs[3] = '{val: 8'd2,   exp_first: 3,   exp_period: 4};
      vecs[4] = '{val: 8'd3,   exp_first: 4,   exp_period: 6};
      vecs[5] = '{val: 8'd7,   exp_first: 8,   exp_period: 14};

      // Reset and default rate.
      rst_n   = 1'b0;
      enable  = 1'b0;
      div_req = 1'b0;
      div_val = '0;
      cyc(); cyc(); cyc();
      chk("rst_cur_div", cur_div, 4);
      chk("rst_clk_out", clk_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tick", tick, 0);
      chk("rst_ack", div_ack, 0);
      chk("rst_err", div_err, 0);
      rst_n = 1'b1;
      cyc();
      enable = 1'b1;
      wait_rise(50, n);
      chk("t1_first_rise", n, 5);
      wait_rise(50, n);
      chk("t1_period", n, 8);
      count_ticks(16, nt);
      chk("t1_ticks_16cyc", nt, 2);

      // Zero request: err pulse, cur_div kept, counting undisturbed.
      div_req = 1'b1;
      div_val = 8'd0;
      exp_err_q.push_back(8'd4);
      cyc();
      div_req = 1'b0;
      chk("t3_err_pulse", div_err, 1);
      chk("t3_busy", busy, 0);
      cyc();
      chk("t3_cur_div", cur_div, 4);
      wait_rise(50, n);
      chk("t3_no_disturb", n, 6);

      // Mid-high request for 2, plus an ignored request while busy.
      div_req = 1'b1;
      div_val = 8'd2;
      exp_ack_q.push_back(8'd2);
      cyc();
      chk("t2_busy", busy, 1);
      chk("t2_still_high", clk_out, 1);
      div_val = 8'd9;
      cyc();
      div_req = 1'b0;
      wait_ack(20, n);
      chk("t2_ack_at_fall", n, 2);
      chk("t2_low_at_ack", clk_out, 0);
      chk("t2_busy_clear", busy, 0);
      wait_rise(20, n);
      chk("t2_low_phase", n, 2);
      wait_rise(20, n);
      chk("t2_period", n, 4);
      chk("t2_cur_div", cur_div, 2);

      // Disable while pending (coincides with a boundary): stop wins, one ack.
      div_req = 1'b1;
      div_val = 8'd6;
      exp_ack_q.push_back(8'd6);
      cyc();
      div_req = 1'b0;
      chk("t4_busy", busy, 1);
      enable = 1'b0;
      cyc();
      chk("t4_ack", div_ack, 1);
      chk("t4_clk_low", clk_out, 0);
      chk("t4_busy_clear", busy, 0);
      cyc(); cyc(); cyc();
      enable = 1'b1;
      wait_rise(50, n);
      chk("t4_first_rise", n, 7);
      wait_rise(50, n);
      chk("t4_period", n, 12);

      // Table: program from STOP, then measure latency, period and ticks.
      for (int i = 0; i < 6; i++) begin
         enable = 1'b0;
         cyc(); cyc();
         chk("tbl_stopped_low", clk_out, 0);
         div_req = 1'b1;
         div_val = vecs[i].val;
         exp_ack_q.push_back(vecs[i].val);
         cyc();
         div_req = 1'b0;
         chk("tbl_ack", div_ack, 1);
         chk("tbl_busy", busy, 0);
         enable = 1'b1;
         wait_rise(600, n);
         chk("tbl_first_rise", n, vecs[i].exp_first);
         wait_rise(600, n);
         chk("tbl_period", n, vecs[i].exp_period);
         count_ticks(2 * vecs[i].exp_period, nt);
         chk("tbl_ticks", nt, 2);
      end

      // Reset while busy: pending value dropped, no ack afterwards.
      div_req = 1'b1;
      div_val = 8'd3;
      cyc();
      div_req = 1'b0;
      chk("t6_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_clk_low", clk_out, 0);
      chk("t6_busy_clear", busy, 0);
      chk("t6_cur_div", cur_div, 4);
      chk("t6_tick", tick, 0);
      prev_clk  = clk_out;
      prev_tick = tick;
      prev_ack  = div_ack;
      prev_err  = div_err;
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) cyc();
      chk("t6_cur_div_after", cur_div, 4);

      // Request sampled on the falling boundary: applied at the next one.
      wait_rise(50, n);
      cyc(); cyc(); cyc();
      div_req = 1'b1;
      div_val = 8'd2;
      exp_ack_q.push_back(8'd2);
      cyc();
      div_req = 1'b0;
      chk("t7_busy", busy, 1);
      chk("t7_fell", clk_out, 0);
      chk("t7_cur_div_old", cur_div, 4);
      wait_ack(30, n);
      chk("t7_ack_next_boundary", n, 8);

      cyc(); cyc();
      chk("sb_ack_drained", exp_ack_q.size(), 0);
      chk("sb_err_drained", exp_err_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
